// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and helpers for the cache memory responder
package cache_pkg;

    // Capture fields are sized for the widest supported configuration; the
    // top zero-extends its inputs into them and slices back out.
    localparam int CAP_ADDR_BITS = 64;
    localparam int CAP_DATA_BITS = 64;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        HOLD
    } resp_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } req_op_t;

    typedef struct packed {
        req_op_t                  op;
        logic [CAP_ADDR_BITS-1:0] addr;
        logic [CAP_DATA_BITS-1:0] data;
    } req_capture_t;

    // Block-aligned word index: low block_bits cleared, wrapped to the storage depth.
    function automatic logic [CAP_ADDR_BITS-1:0] block_base(
        input logic [CAP_ADDR_BITS-1:0] addr,
        input int                       block_bits,
        input int                       depth_bits
    );
        logic [CAP_ADDR_BITS-1:0] mask;
        mask = (CAP_ADDR_BITS'(1) << depth_bits) - CAP_ADDR_BITS'(1);
        mask = mask & ~((CAP_ADDR_BITS'(1) << block_bits) - CAP_ADDR_BITS'(1));
        return addr & mask;
    endfunction

endpackage

// File: rtl/cache_mem_array.sv
// rtl/cache_mem_array.sv - word storage with one write port and one block-wide read port
//
// Ports:
//   clk, reset     clock and synchronous active-high reset (re-initializes storage)
//   wr_en          write wr_data to word wr_idx on this edge
//   wr_idx         word index of the write
//   wr_data        word to write
//   rd_base        block-aligned word index of the read
//   rd_data        combinational read, [i] = word at rd_base + i
module cache_mem_array #(
    parameter int DATA_BITS      = 32,
    parameter int BLOCK_BITS     = 2,
    parameter int MEM_DEPTH_BITS = 10,
    parameter int INIT_INDEX     = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [MEM_DEPTH_BITS-1:0] wr_idx,
    input  logic [DATA_BITS-1:0]      wr_data,
    input  logic [MEM_DEPTH_BITS-1:0] rd_base,
    output logic [DATA_BITS-1:0]      rd_data [2**BLOCK_BITS]
);

    localparam int DEPTH     = 2**MEM_DEPTH_BITS;
    localparam int NUM_WORDS = 2**BLOCK_BITS;

    logic [DATA_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= (INIT_INDEX != 0) ? DATA_BITS'(k) : '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // rd_base is block aligned and the depth is a whole number of blocks,
    // so base + i never wraps.
    always_comb begin
        for (int i = 0; i < NUM_WORDS; i++) begin
            rd_data[i] = mem[rd_base + MEM_DEPTH_BITS'(i)];
        end
    end

endmodule

// File: rtl/cache_mem_responder.sv
// rtl/cache_mem_responder.sv - memory-side responder for cache block fills and word write-backs
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   prop_address      request word address (bits above MEM_DEPTH_BITS ignored)
//   prop_read_en      block-fill request
//   prop_write_en     word write-back request
//   prop_write_data   write-back word
//   prop_valid        qualifies prop_* this cycle
//   mem_valid         one-cycle response strobe (read data or write ack)
//   mem_data          [i] = word at block base + i during a read response, else zero
//   busy              request in flight; new requests are dropped
//   err               one-cycle pulse after a request with both enables set
module cache_mem_responder
    import cache_pkg::*;
#(
    parameter int RAM_ADDRESS_BITS = 32,
    parameter int DATA_BITS        = 32,
    parameter int BLOCK_BITS       = 2,
    parameter int MEM_DEPTH_BITS   = 10,
    parameter int LATENCY          = 3,
    parameter int INIT_INDEX       = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [RAM_ADDRESS_BITS-1:0] prop_address,
    input  logic                        prop_read_en,
    input  logic                        prop_write_en,
    input  logic [DATA_BITS-1:0]        prop_write_data,
    input  logic                        prop_valid,
    output logic                        mem_valid,
    output logic [DATA_BITS-1:0]        mem_data [2**BLOCK_BITS],
    output logic                        busy,
    output logic                        err
);

    localparam int NUM_WORDS = 2**BLOCK_BITS;
    localparam int CNT_BITS  = $clog2(LATENCY + 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $fatal(1, "cache_mem_responder: LATENCY must be in 1..15");
    end
    if (MEM_DEPTH_BITS < BLOCK_BITS || MEM_DEPTH_BITS >= CAP_ADDR_BITS) begin : g_bad_depth
        $fatal(1, "cache_mem_responder: MEM_DEPTH_BITS out of range");
    end
    if (DATA_BITS > CAP_DATA_BITS || RAM_ADDRESS_BITS > CAP_ADDR_BITS) begin : g_bad_width
        $fatal(1, "cache_mem_responder: DATA_BITS or RAM_ADDRESS_BITS too wide");
    end

    resp_state_t          state_q, state_d;
    logic [CNT_BITS-1:0]  cnt_q;
    req_capture_t         cap_q;
    req_capture_t         req_now;
    logic                 err_q;
    logic [DATA_BITS-1:0] rd_q [NUM_WORDS];

    logic                 accept;
    logic                 illegal;
    logic                 entering_resp;
    logic [CAP_ADDR_BITS-1:0] base_full;
    logic [MEM_DEPTH_BITS-1:0] rd_base;
    logic [DATA_BITS-1:0] rd_data [NUM_WORDS];
    logic                 wr_en;
    logic                 unused_bits;

    // Requests are only looked at in IDLE; anything arriving while busy is dropped silently.
    assign accept  = (state_q == IDLE) && prop_valid && (prop_read_en ^ prop_write_en);
    assign illegal = (state_q == IDLE) && prop_valid && prop_read_en && prop_write_en;

    // With LATENCY==1 the storage access happens on the accepting edge itself,
    // before the capture register holds the request, so use the live inputs in IDLE.
    always_comb begin
        req_now = cap_q;
        if (state_q == IDLE) begin
            req_now.op   = prop_write_en ? OP_WRITE : OP_READ;
            req_now.addr = CAP_ADDR_BITS'(prop_address);
            req_now.data = CAP_DATA_BITS'(prop_write_data);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (cnt_q == CNT_BITS'(1)) state_d = RESP;
            RESP:    state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Writes commit and read data is sampled only on the edge entering RESP,
    // so a reset during WAIT discards the request without touching storage.
    assign entering_resp = (state_d == RESP) && (state_q != RESP);
    assign wr_en         = entering_resp && (req_now.op == OP_WRITE);
    assign base_full     = block_base(req_now.addr, BLOCK_BITS, MEM_DEPTH_BITS);
    assign rd_base       = base_full[MEM_DEPTH_BITS-1:0];
    assign unused_bits   = ^{req_now, base_full};

    cache_mem_array #(
        .DATA_BITS      (DATA_BITS),
        .BLOCK_BITS     (BLOCK_BITS),
        .MEM_DEPTH_BITS (MEM_DEPTH_BITS),
        .INIT_INDEX     (INIT_INDEX)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_idx  (req_now.addr[MEM_DEPTH_BITS-1:0]),
        .wr_data (req_now.data[DATA_BITS-1:0]),
        .rd_base (rd_base),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            err_q   <= illegal;
            if (accept) begin
                cap_q <= req_now;
                cnt_q <= CNT_BITS'(LATENCY - 1);
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - CNT_BITS'(1);
            end
            if (entering_resp && req_now.op == OP_READ) begin
                for (int i = 0; i < NUM_WORDS; i++) begin
                    rd_q[i] <= rd_data[i];
                end
            end
        end
    end

    assign mem_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign err       = err_q;

    always_comb begin
        for (int i = 0; i < NUM_WORDS; i++) begin
            mem_data[i] = (mem_valid && cap_q.op == OP_READ) ? rd_q[i] : '0;
        end
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// tb/tb_cache_mem_responder.sv - self-checking bench for cache_mem_responder
module tb_cache_mem_responder;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NW  = 4;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] prop_address;
    logic          prop_read_en;
    logic          prop_write_en;
    logic [DW-1:0] prop_write_data;
    logic          prop_valid;

    logic          mem_valid, busy, err;
    logic [DW-1:0] mem_data [NW];
    logic          mem_valid1, busy1, err1;
    logic [DW-1:0] mem_data1 [NW];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_mem_responder #(.LATENCY(LAT)) dut (
        .clk             (clk),
        .reset           (reset),
        .prop_address    (prop_address),
        .prop_read_en    (prop_read_en),
        .prop_write_en   (prop_write_en),
        .prop_write_data (prop_write_data),
        .prop_valid      (prop_valid),
        .mem_valid       (mem_valid),
        .mem_data        (mem_data),
        .busy            (busy),
        .err             (err)
    );

    cache_mem_responder #(.LATENCY(1)) dut1 (
        .clk             (clk),
        .reset           (reset),
        .prop_address    (prop_address),
        .prop_read_en    (prop_read_en),
        .prop_write_en   (prop_write_en),
        .prop_write_data (prop_write_data),
        .prop_valid      (prop_valid),
        .mem_valid       (mem_valid1),
        .mem_data        (mem_data1),
        .busy            (busy1),
        .err             (err1)
    );

    typedef struct {
        logic          rd;
        logic          wr;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic          exp_err;
        logic [127:0]  exp_blk;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [127:0] blk(input logic [31:0] w0, input logic [31:0] w1,
                                         input logic [31:0] w2, input logic [31:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    function automatic logic [127:0] got_blk();
        return {mem_data[3], mem_data[2], mem_data[1], mem_data[0]};
    endfunction

    function automatic logic [127:0] got_blk1();
        return {mem_data1[3], mem_data1[2], mem_data1[1], mem_data1[0]};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        prop_valid      = 1'b1;
        prop_read_en    = rd;
        prop_write_en   = wr;
        prop_address    = addr;
        prop_write_data = data;
    endtask

    task automatic drop();
        prop_valid    = 1'b0;
        prop_read_en  = 1'b0;
        prop_write_en = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || busy1) && n < 30) begin
            step();
            n++;
        end
        if (n >= 30) check({name, "_idle_timeout"}, 128'(n), 128'(0));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        int nv;
        string tag;
        tag = $sformatf("vec%0d", idx);
        drive(v.rd, v.wr, v.addr, v.wdata);
        step();
        drop();
        if (v.exp_err) begin
            check({tag, "_err_pulse"}, 128'(err), 128'(1));
            check({tag, "_err_not_busy"}, 128'(busy), 128'(0));
            step();
            check({tag, "_err_one_cycle"}, 128'(err), 128'(0));
            nv = 0;
            for (int k = 0; k < 6; k++) begin
                if (mem_valid) nv++;
                step();
            end
            check({tag, "_err_no_valid"}, 128'(nv), 128'(0));
        end else begin
            lat = 0;
            while (!mem_valid && lat < 20) begin
                step();
                lat++;
            end
            check({tag, "_latency"}, 128'(lat + 1), 128'(LAT));
            check({tag, "_data"}, got_blk(), v.rd ? v.exp_blk : 128'(0));
            step();
            check({tag, "_valid_one_cycle"}, 128'(mem_valid), 128'(0));
            check({tag, "_hold_busy"}, 128'(busy), 128'(1));
            step();
            check({tag, "_idle_after_hold"}, 128'(busy), 128'(0));
        end
        wait_idle(tag);
    endtask

    initial begin
        int nv;
        int nb;
        int pos;

        vecs[0]  = '{1'b1, 1'b0, 32'h10,        32'h0,    1'b0, blk(32'h10,   32'h11,   32'h12,  32'h13)};
        vecs[1]  = '{1'b0, 1'b1, 32'h11,        32'haaaa, 1'b0, 128'(0)};
        vecs[2]  = '{1'b1, 1'b0, 32'h12,        32'h0,    1'b0, blk(32'h10,   32'haaaa, 32'h12,  32'h13)};
        vecs[3]  = '{1'b1, 1'b1, 32'h10,        32'h5555, 1'b1, 128'(0)};
        vecs[4]  = '{1'b1, 1'b0, 32'h13,        32'h0,    1'b0, blk(32'h10,   32'haaaa, 32'h12,  32'h13)};
        vecs[5]  = '{1'b1, 1'b0, 32'h3fd,       32'h0,    1'b0, blk(32'h3fc,  32'h3fd,  32'h3fe, 32'h3ff)};
        vecs[6]  = '{1'b1, 1'b0, 32'hffff_f404, 32'h0,    1'b0, blk(32'h4,    32'h5,    32'h6,   32'h7)};
        vecs[7]  = '{1'b0, 1'b1, 32'hffff_fc08, 32'h1234, 1'b0, 128'(0)};
        vecs[8]  = '{1'b1, 1'b0, 32'h9,         32'h0,    1'b0, blk(32'h1234, 32'h9,    32'ha,   32'hb)};
        vecs[9]  = '{1'b0, 1'b1, 32'h3ff,       32'h77,   1'b0, 128'(0)};
        vecs[10] = '{1'b1, 1'b0, 32'h3fc,       32'h0,    1'b0, blk(32'h3fc,  32'h3fd,  32'h3fe, 32'h77)};

        // Reset state
        drop();
        prop_address    = '0;
        prop_write_data = '0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("rst_mem_valid", 128'(mem_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        check("rst_mem_data", got_blk(), 128'(0));
        check("rst_busy_lat1", 128'(busy1), 128'(0));

        // Busy/valid profile of a single read of 'h10
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        step();
        drop();
        nv = 0; nb = 0; pos = -1;
        for (int k = 0; k < 6; k++) begin
            if (busy) nb++;
            if (mem_valid) begin
                nv++;
                pos = k;
                check("profile_data", got_blk(), blk(32'h10, 32'h11, 32'h12, 32'h13));
            end
            step();
        end
        check("profile_valid_count", 128'(nv), 128'(1));
        check("profile_valid_pos", 128'(pos + 1), 128'(LAT));
        check("profile_busy_cycles", 128'(nb), 128'(LAT + 1));
        wait_idle("profile");

        // Table-driven vectors
        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], i);
        end

        // Read enable held across the response: one response, HOLD blocks, re-accept at t0+5
        drive(1'b1, 1'b0, 32'h14, 32'h0);
        step();
        nv = 0;
        for (int k = 0; k < 4; k++) begin
            if (mem_valid) nv++;
            step();
        end
        check("held_one_response", 128'(nv), 128'(1));
        check("held_idle_at_t0p4", 128'(busy), 128'(0));
        step();
        check("held_reaccept_t0p5", 128'(busy), 128'(1));
        drop();
        wait_idle("held");

        // Request while busy is dropped without err
        drive(1'b1, 1'b0, 32'h20, 32'h0);
        step();
        drive(1'b0, 1'b1, 32'h20, 32'hbeef);
        step();
        check("busy_drop_no_err", 128'(err), 128'(0));
        drop();
        wait_idle("busy_drop");
        run_vec('{1'b1, 1'b0, 32'h20, 32'h0, 1'b0, blk(32'h20, 32'h21, 32'h22, 32'h23)}, 100);

        // Reset during WAIT of a write to 'h30
        drive(1'b0, 1'b1, 32'h30, 32'hdead);
        step();
        drop();
        check("abort_in_wait", 128'(busy), 128'(1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy_cleared", 128'(busy), 128'(0));
        nv = 0;
        for (int k = 0; k < 6; k++) begin
            if (mem_valid) nv++;
            step();
        end
        check("abort_no_valid", 128'(nv), 128'(0));
        run_vec('{1'b1, 1'b0, 32'h30, 32'h0, 1'b0, blk(32'h30, 32'h31, 32'h32, 32'h33)}, 101);

        // LATENCY=1 instance: response visible right after the accepting edge
        drive(1'b1, 1'b0, 32'h18, 32'h0);
        step();
        drop();
        check("lat1_valid", 128'(mem_valid1), 128'(1));
        check("lat1_data", got_blk1(), blk(32'h18, 32'h19, 32'h1a, 32'h1b));
        step();
        check("lat1_valid_drop", 128'(mem_valid1), 128'(0));
        check("lat1_hold_busy", 128'(busy1), 128'(1));
        check("lat1_hold_data", got_blk1(), 128'(0));
        step();
        check("lat1_idle", 128'(busy1), 128'(0));
        wait_idle("lat1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
